mem2serial_words: RTL and testbench

//  Drains DW-bit words from a ringbuffer read port and streams them byte-by-byte into uart_tx.

---
 rtl/mem2serial_words.sv | 164 ++++++++++++++++
 tb/tb_mem2serial_words.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2serial_words.sv
// rtl/mem2serial_words.sv - drains DW-bit ringbuffer words into uart_tx as raw or hex-ASCII bytes
// Optional CR/LF word terminator: define MEM2SERIAL_TERMINATOR_EN.
module mem2serial_words #(
  parameter int DW        = 48,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CW        = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read_empty,
  output logic          read_clock_enable,
  input  logic [DW-1:0] read_data,
  input  logic          hex_mode,
  input  logic          uart_ready,
  output logic          uart_clock_enable,
  output logic [7:0]    uart_data,
  output logic          busy,
  output logic [CW-1:0] word_count
);

`ifdef MEM2SERIAL_TERMINATOR_EN
  typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_SEND, S_WAIT, S_TERM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_SEND, S_WAIT} state_t;
`endif

  localparam int            NB      = DW / 8;
  localparam logic [7:0]    RAW_CNT = 8'(NB);
  localparam logic [7:0]    HEX_CNT = 8'(2 * NB);
  localparam logic [CW-1:0] WC_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [DW-1:0] r_word;
  logic          r_hex;
  logic          r_nib_lo;
  logic [7:0]    r_cnt;
  logic          r_first;
  logic          r_read_ce;
  logic          r_uart_ce;
  logic [7:0]    r_uart_data;
  logic [CW-1:0] r_word_count;
`ifdef MEM2SERIAL_TERMINATOR_EN
  logic          r_term_active;
  logic          r_term_lf;
`endif

  logic [7:0] w_byte;
  logic [3:0] w_nibble;
  logic [7:0] w_hex_char;
  logic [7:0] w_char;

  // The word register is shifted as bytes go out, so the current byte is always at one end.
  always_comb begin
    w_byte     = MSB_FIRST ? r_word[DW-1 -: 8] : r_word[7:0];
    w_nibble   = r_nib_lo ? w_byte[3:0] : w_byte[7:4];
    w_hex_char = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble}) : (8'h37 + {4'h0, w_nibble});
    w_char     = r_hex ? w_hex_char : w_byte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_word        <= '0;
      r_hex         <= 1'b0;
      r_nib_lo      <= 1'b0;
      r_cnt         <= 8'd0;
      r_first       <= 1'b0;
      r_read_ce     <= 1'b0;
      r_uart_ce     <= 1'b0;
      r_uart_data   <= 8'd0;
      r_word_count  <= '0;
`ifdef MEM2SERIAL_TERMINATOR_EN
      r_term_active <= 1'b0;
      r_term_lf     <= 1'b0;
`endif
    end else begin
      r_read_ce <= 1'b0;
      r_uart_ce <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!read_empty) begin
            r_read_ce <= 1'b1;
            r_state   <= S_POP;
          end
        end
        S_POP: r_state <= S_LATCH;
        S_LATCH: begin
          r_word   <= read_data;
          r_hex    <= hex_mode;
          r_nib_lo <= 1'b0;
          r_cnt    <= hex_mode ? HEX_CNT : RAW_CNT;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (uart_ready) begin
            r_uart_ce   <= 1'b1;
            r_uart_data <= w_char;
            r_first     <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // uart_tx still shows ready during the strobe cycle; only trust it afterwards.
          if (r_first) begin
            r_first <= 1'b0;
          end else if (uart_ready) begin
`ifdef MEM2SERIAL_TERMINATOR_EN
            if (r_term_active) begin
              if (r_term_lf) begin
                r_term_active <= 1'b0;
                r_term_lf     <= 1'b0;
                r_word_count  <= r_word_count + WC_ONE;
                r_state       <= S_IDLE;
              end else begin
                r_term_lf <= 1'b1;
                r_state   <= S_TERM;
              end
            end else
`endif
            begin
              if (r_hex && !r_nib_lo) begin
                r_nib_lo <= 1'b1;
              end else begin
                r_nib_lo <= 1'b0;
                r_word   <= MSB_FIRST ? (r_word << 8) : (r_word >> 8);
              end
              r_cnt <= r_cnt - 8'd1;
              if (r_cnt == 8'd1) begin
`ifdef MEM2SERIAL_TERMINATOR_EN
                r_term_active <= 1'b1;
                r_term_lf     <= 1'b0;
                r_state       <= S_TERM;
`else
                r_word_count  <= r_word_count + WC_ONE;
                r_state       <= S_IDLE;
`endif
              end else begin
                r_state <= S_SEND;
              end
            end
          end
        end
`ifdef MEM2SERIAL_TERMINATOR_EN
        S_TERM: begin
          if (uart_ready) begin
            r_uart_ce   <= 1'b1;
            r_uart_data <= r_term_lf ? 8'h0A : 8'h0D;
            r_first     <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_clock_enable = r_read_ce;
  assign uart_clock_enable = r_uart_ce;
  assign uart_data         = r_uart_data;
  assign busy              = (r_state != S_IDLE);
  assign word_count        = r_word_count;

endmodule

// File: tb/tb_mem2serial_words.sv
// tb/tb_mem2serial_words.sv - scoreboard bench for mem2serial_words with ringbuffer and uart_tx models
module tb_mem2serial_words;
  localparam int DW  = 48;
  localparam int NB  = DW / 8;
  localparam int CW  = 16;
  localparam int DW2 = 16;
  localparam int NB2 = DW2 / 8;
  localparam int CW2 = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT 1: DW=48, LSB first, CW=16
  logic          read_empty = 1'b1;
  logic          read_clock_enable;
  logic [DW-1:0] read_data = '0;
  logic          hex_mode = 1'b0;
  logic          uart_ready = 1'b1;
  logic          uart_clock_enable;
  logic [7:0]    uart_data;
  logic          busy;
  logic [CW-1:0] word_count;

  // DUT 2: DW=16, MSB first, CW=2
  logic           read_empty2 = 1'b1;
  logic           read_clock_enable2;
  logic [DW2-1:0] read_data2 = '0;
  logic           hex_mode2 = 1'b0;
  logic           uart_ready2 = 1'b1;
  logic           uart_clock_enable2;
  logic [7:0]     uart_data2;
  logic           busy2;
  logic [CW2-1:0] word_count2;

  mem2serial_words #(.DW(DW), .MSB_FIRST(1'b0), .CW(CW)) dut (
    .clock(clock), .reset(reset), .read_empty(read_empty), .read_clock_enable(read_clock_enable),
    .read_data(read_data), .hex_mode(hex_mode), .uart_ready(uart_ready),
    .uart_clock_enable(uart_clock_enable), .uart_data(uart_data), .busy(busy), .word_count(word_count)
  );

  mem2serial_words #(.DW(DW2), .MSB_FIRST(1'b1), .CW(CW2)) dut2 (
    .clock(clock), .reset(reset), .read_empty(read_empty2), .read_clock_enable(read_clock_enable2),
    .read_data(read_data2), .hex_mode(hex_mode2), .uart_ready(uart_ready2),
    .uart_clock_enable(uart_clock_enable2), .uart_data(uart_data2), .busy(busy2), .word_count(word_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]  rb_q[$];
  logic [DW2-1:0] rb2_q[$];
  logic [7:0]     exp_q[$];
  logic [7:0]     exp2_q[$];
  int exp_words  = 0;
  int exp_words2 = 0;
  int pops       = 0;
  int pops2      = 0;
  int n_strobes  = 0;
  bit stall_en   = 1'b0;
  bit hold_low   = 1'b0;
  int ubusy      = 0;
  int ubusy2     = 0;
  logic prev_ready  = 1'b1;
  logic prev_ready2 = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k-th character the uart should see for word w: pick the byte by order, then text or raw.
  function automatic logic [7:0] exp_char(input logic [63:0] w, input int nb, input bit msb,
                                          input bit hex, input int k);
    string digits;
    int    bi;
    int    b;
    logic [7:0] v;
    logic [3:0] nib;
    digits = "0123456789ABCDEF";
    bi = hex ? k / 2 : k;
    b  = msb ? nb - 1 - bi : bi;
    v  = w[8*b +: 8];
    if (!hex) return v;
    nib = (k % 2 == 0) ? v[7:4] : v[3:0];
    return digits[int'(nib)];
  endfunction

  task automatic push_word(input logic [DW-1:0] w, input bit hex);
    int nch;
    nch = hex ? 2 * NB : NB;
    for (int k = 0; k < nch; k++) exp_q.push_back(exp_char(64'(w), NB, 1'b0, hex, k));
`ifdef MEM2SERIAL_TERMINATOR_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    rb_q.push_back(w);
    exp_words++;
  endtask

  task automatic push_word2(input logic [DW2-1:0] w, input bit hex);
    int nch;
    nch = hex ? 2 * NB2 : NB2;
    for (int k = 0; k < nch; k++) exp2_q.push_back(exp_char(64'(w), NB2, 1'b1, hex, k));
`ifdef MEM2SERIAL_TERMINATOR_EN
    exp2_q.push_back(8'h0D);
    exp2_q.push_back(8'h0A);
`endif
    rb2_q.push_back(w);
    exp_words2++;
  endtask

  // Ringbuffer models: registered read, data valid the cycle after the pop strobe.
  always @(posedge clock) begin
    if (read_clock_enable) begin
      check("pop_nonempty", 64'(rb_q.size() != 0), 64'd1);
      if (rb_q.size() != 0) read_data <= rb_q.pop_front();
      pops++;
    end
    read_empty <= (rb_q.size() == 0);
    if (read_clock_enable2) begin
      check("pop2_nonempty", 64'(rb2_q.size() != 0), 64'd1);
      if (rb2_q.size() != 0) read_data2 <= rb2_q.pop_front();
      pops2++;
    end
    read_empty2 <= (rb2_q.size() == 0);
  end

  // uart_tx models: ready drops after each strobe, stays low a random while.
  always @(posedge clock) begin
    if (hold_low) begin
      uart_ready <= 1'b0;
    end else if (uart_clock_enable) begin
      uart_ready <= 1'b0;
      ubusy      <= int'($urandom_range(1, 4));
    end else if (ubusy > 0) begin
      ubusy <= ubusy - 1;
    end else begin
      uart_ready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (uart_clock_enable2) begin
      uart_ready2 <= 1'b0;
      ubusy2      <= 2;
    end else if (ubusy2 > 0) begin
      ubusy2 <= ubusy2 - 1;
    end else begin
      uart_ready2 <= 1'b1;
    end
  end

  // Scoreboard monitors
  always @(negedge clock) begin
    if (!reset) begin
      if (uart_clock_enable) begin
        n_strobes++;
        check("strobe_when_ready", 64'(prev_ready), 64'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", uart_data);
        end else begin
          check("uart_byte", 64'(uart_data), 64'(exp_q.pop_front()));
        end
      end
      if (read_clock_enable) check("pop_busy", 64'(busy), 64'd1);
      if (uart_clock_enable2) begin
        check("strobe2_when_ready", 64'(prev_ready2), 64'd1);
        if (exp2_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte2: got %0h expected none", uart_data2);
        end else begin
          check("uart_byte2", 64'(uart_data2), 64'(exp2_q.pop_front()));
        end
      end
    end
    prev_ready  = uart_ready;
    prev_ready2 = uart_ready2;
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((rb_q.size() != 0 || busy || read_clock_enable || exp_q.size() != 0) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    check({name, "_timeout"}, 64'(t < 5000), 64'd1);
    check({name, "_word_count"}, 64'(word_count), 64'(exp_words % (1 << CW)));
  endtask

  task automatic wait_exp_size(input int n);
    int t;
    t = 0;
    while (exp_q.size() > n && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check("wait_strobe_timeout", 64'(t < 2000), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int s0;
    int hits;
    logic [DW-1:0] w;
    logic [15:0]   w2;

    #1;
    check("reset_rce", 64'(read_clock_enable), 64'd0);
    check("reset_uce", 64'(uart_clock_enable), 64'd0);
    check("reset_udata", 64'(uart_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wc", 64'(word_count), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // empty ringbuffer: nothing happens
    hits = 0;
    repeat (100) begin
      @(negedge clock);
      if (read_clock_enable || busy) hits++;
    end
    check("idle_activity", 64'(hits), 64'd0);
    check("idle_wc", 64'(word_count), 64'd0);

    // "hello!" raw
    hex_mode = 1'b0;
    push_word(48'h216f6c6c6568, 1'b0);
    drain("hello");

    // hex, low byte first
    hex_mode = 1'b1;
    push_word(48'h00000000A53C, 1'b1);
    drain("hex_a53c");

    // three queued raw words with random stalls
    stall_en = 1'b1;
    hex_mode = 1'b0;
    p0 = pops;
    s0 = n_strobes;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom}, 1'b0);
    drain("three");
    check("three_pops", 64'(pops - p0), 64'd3);
`ifdef MEM2SERIAL_TERMINATOR_EN
    check("three_strobes", 64'(n_strobes - s0), 64'(3 * (NB + 2)));
`else
    check("three_strobes", 64'(n_strobes - s0), 64'(3 * NB));
`endif

    // random batches alternating mode
    for (int b = 0; b < 4; b++) begin
      hex_mode = b[0];
      for (int i = 0; i < 3; i++) push_word({$urandom, $urandom}, b[0]);
      drain("batch");
    end
    stall_en = 1'b0;

    // hex_mode change mid-word is ignored
    hex_mode = 1'b1;
    push_word({$urandom, $urandom}, 1'b1);
    wait_exp_size(exp_q.size() - 1);
    hex_mode = 1'b0;
    drain("midword_mode");

    // uart never ready: one pop, no strobes
    hold_low = 1'b1;
    repeat (2) @(negedge clock);
    p0 = pops;
    push_word({$urandom, $urandom}, 1'b0);
    push_word({$urandom, $urandom}, 1'b0);
    s0 = exp_q.size();
    repeat (50) @(negedge clock);
    check("hold_pops", 64'(pops - p0), 64'd1);
    check("hold_no_strobe", 64'(exp_q.size()), 64'(s0));
    check("hold_busy", 64'(busy), 64'd1);
    hold_low = 1'b0;
    drain("hold_release");

    // reset after second byte of a word
    push_word({$urandom, $urandom}, 1'b0);
    wait_exp_size(exp_q.size() - 2);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_rce", 64'(read_clock_enable), 64'd0);
    check("midreset_uce", 64'(uart_clock_enable), 64'd0);
    check("midreset_udata", 64'(uart_data), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_wc", 64'(word_count), 64'd0);
    exp_q.delete();
    exp_words  = 0;
    exp_words2 = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    w = 48'h0102030405A6;
    push_word(w, 1'b0);
    drain("after_reset");

    // second instance: MSB first, hex, 2-bit counter wraps after four words
    hex_mode2 = 1'b1;
    push_word2(16'hA53C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w2 = 16'($urandom);
      push_word2(w2, 1'b1);
    end
    hits = 0;
    while ((rb2_q.size() != 0 || busy2 || read_clock_enable2 || exp2_q.size() != 0) && hits < 5000) begin
      @(negedge clock);
      hits++;
    end
    check("dut2_timeout", 64'(hits < 5000), 64'd1);
    check("dut2_pops", 64'(pops2), 64'd5);
    check("dut2_wc_wrap", 64'(word_count2), 64'(exp_words2 % (1 << CW2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
